alu_sched: RTL

Round-robin scheduler that shares one `ALU_S`-style 2-bit ALU between NREQ requesters. It accepts one operation at a time through a req/gnt handshake and drives the ALU operand and select ports. It waits the ALU's fixed pipeline latency, then returns the 4-bit result and the carry/zero flags tagged with the requester ID. It sits between the requesting control logic and the single ALU instance.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_sched_rr_arb.sv | 37 +++
 rtl/alu_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: operand/result widths,
// op-select encodings and the scheduler FSM state type.
package alu_pkg;

    localparam int OPW  = 2;    // operand width
    localparam int SELW = 2;    // op-select width
    localparam int RESW = 4;    // result width

    // Only ADD is defined; the other encodings are reserved and passed
    // through to the ALU unchanged.
    localparam logic [SELW-1:0] ALU_ADD = 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    // Next requester index after id, wrapping to 0 past n-1.
    function automatic int rr_next(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Combinational round-robin pick: the winner is the first requester at or
// after ptr, wrapping modulo NREQ. The pointer register lives in the caller.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  win,
    output logic            any
);

    // Choose the set request with the smallest forward distance from ptr.
    always_comb begin
        int v_best;
        int v_dist;
        v_best = NREQ;
        v_dist = 0;
        gnt    = '0;
        win    = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_dist = i - int'(ptr);
            if (v_dist < 0) begin
                v_dist = v_dist + NREQ;
            end
            if (req[i] && (v_dist < v_best)) begin
                v_best = v_dist;
                gnt    = '0;
                gnt[i] = 1'b1;
                win    = IDW'(i);
            end
        end
        any = (v_best < NREQ);
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one pipelined 2-bit ALU between NREQ
// requesters. One operation is in flight at a time: grant, wait out the ALU
// latency, then hold a tagged response until the consumer takes it.
//
//   state | meaning
//   IDLE  | arbitrating; gnt pulses for the winner and operands are latched
//   WAIT  | counting down the ALU pipeline latency
//   RESP  | response held on rsp_*, waiting for rsp_ready
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
)(
    input  logic                   clk,
    input  logic                   en,
    input  logic [NREQ-1:0]        req,
    input  logic [OPW*NREQ-1:0]    req_a,
    input  logic [OPW*NREQ-1:0]    req_b,
    input  logic [SELW*NREQ-1:0]   req_s,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [RESW-1:0]        rsp_y,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic [OPW-1:0]         alu_a,
    output logic [OPW-1:0]         alu_b,
    output logic [SELW-1:0]        alu_s,
    input  logic [RESW-1:0]        alu_y,
    input  logic                   alu_carry,
    input  logic                   alu_zero
);

    localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    sched_state_e      r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_cur_id;
    logic [CNTW-1:0]   r_cnt;
    logic              r_rsp_valid;
    logic [IDW-1:0]    r_rsp_id;
    logic [RESW-1:0]   r_rsp_y;
    logic              r_rsp_carry;
    logic              r_rsp_zero;
    logic [OPW-1:0]    r_alu_a;
    logic [OPW-1:0]    r_alu_b;
    logic [SELW-1:0]   r_alu_s;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [IDW-1:0]    w_arb_win;
    logic              w_arb_any;
    logic [OPW-1:0]    w_sel_a;
    logic [OPW-1:0]    w_sel_b;
    logic [SELW-1:0]   w_sel_s;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req  (req),
        .ptr  (r_ptr),
        .gnt  (w_arb_gnt),
        .win  (w_arb_win),
        .any  (w_arb_any)
    );

    // Route the winning requester's operand and select slices to the ALU regs.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_win == IDW'(i)) begin
                w_sel_a = req_a[i*OPW +: OPW];
                w_sel_b = req_b[i*OPW +: OPW];
                w_sel_s = req_s[i*SELW +: SELW];
            end
        end
    end

    // Grant only while arbitrating; held low during reset so a request
    // present while en is low never shows up as an acceptance.
    assign gnt = (en && (r_state == IDLE)) ? w_arb_gnt : '0;

    // Scheduler FSM: accept, wait out the ALU latency, hold response.
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cur_id    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
                        r_alu_s  <= w_sel_s;
                        r_cur_id <= w_arb_win;
                        r_cnt    <= CNTW'(ALU_LAT - 1);
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_carry <= alu_carry;
                        r_rsp_zero  <= alu_zero;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= IDW'(rr_next(int'(r_cur_id), NREQ));
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;

endmodule
